// File: rtl/sseg_scan_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan_bcd
//  Purpose  : N-digit multiplexed common-anode seven-segment driver with a
//             sequential shift-add-3 binary-to-BCD converter, hex pass-through,
//             leading-zero blanking, per-digit decimal points and overflow
//             indication (all digits show "-").
//  Ports    : clk, reset (async, active-high)
//             i_value/i_load/i_hex_mode : value capture (hex_mode sampled w/ load)
//             i_blank_lz, i_dp_in       : live display controls
//             i_brightness              : dimming level (only with SSEG_DIM_EN)
//             o_busy, o_overflow        : converter status
//             o_seg_n, o_dp_n, o_an_n   : registered active-low display pins
//  Options  : `define SSEG_DIM_EN adds i_brightness anode-PWM dimming.
//  Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_bcd #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int REFRESH_W  = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      i_value,
  input  logic                  i_load,
  input  logic                  i_hex_mode,
  input  logic                  i_blank_lz,
  input  logic [NUM_DIGITS-1:0] i_dp_in,
`ifdef SSEG_DIM_EN
  input  logic [3:0]            i_brightness,
`endif
  output logic                  o_busy,
  output logic                  o_overflow,
  output logic [6:0]            o_seg_n,
  output logic                  o_dp_n,
  output logic [NUM_DIGITS-1:0] o_an_n
);

  localparam int c_DW = 4 * NUM_DIGITS;
  localparam int c_IW = $clog2(NUM_DIGITS);
  localparam int c_CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BIN_W-1:0]    r_bin;
  logic [c_DW-1:0]     r_bcd;
  logic [c_CW-1:0]     r_cnt;
  logic                r_sticky;
  logic [c_DW-1:0]     r_disp;
  logic                r_overflow;
  logic [REFRESH_W-1:0] r_refresh;
  logic [c_IW-1:0]     r_idx;
  logic [6:0]          r_seg_n;
  logic                r_dp_n;
  logic [NUM_DIGITS-1:0] r_an_n;

  logic [c_DW-1:0]     w_adj;
  logic [c_DW-1:0]     w_hex;
  logic                w_hex_ovf;
  logic [NUM_DIGITS-1:0] w_nz;
  logic [3:0]          w_digit;
  logic                w_dp;
  logic                w_blank;
  logic [6:0]          w_seg;
  logic [NUM_DIGITS-1:0] w_an_sel;
  logic [NUM_DIGITS-1:0] w_an;

  // Hex pass-through: zero-extend or truncate to the display width.
  generate
    if (BIN_W > c_DW) begin : g_hex_trunc
      assign w_hex     = i_value[c_DW-1:0];
      assign w_hex_ovf = |i_value[BIN_W-1:c_DW];
    end else if (BIN_W == c_DW) begin : g_hex_exact
      assign w_hex     = i_value;
      assign w_hex_ovf = 1'b0;
    end else begin : g_hex_ext
      assign w_hex     = {{(c_DW-BIN_W){1'b0}}, i_value};
      assign w_hex_ovf = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_load && !i_hex_mode) w_state_nxt = S_SHIFT;
      S_SHIFT:  if (r_cnt == c_CW'(1))     w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_sticky   <= 1'b0;
      r_disp     <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            if (i_hex_mode) begin
              r_disp     <= w_hex;
              r_overflow <= w_hex_ovf;
            end else begin
              r_bin    <= i_value;
              r_bcd    <= '0;
              r_cnt    <= c_CW'(BIN_W);
              r_sticky <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          // A 1 leaving the top nibble means the value needs another digit.
          r_bcd    <= {w_adj[c_DW-2:0], r_bin[BIN_W-1]};
          r_bin    <= r_bin << 1;
          r_sticky <= r_sticky | w_adj[c_DW-1];
          r_cnt    <= r_cnt - c_CW'(1);
        end
        S_COMMIT: begin
          r_disp     <= r_bcd;
          r_overflow <= r_sticky;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------- scan
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh <= '0;
      r_idx     <= '0;
    end else begin
      r_refresh <= r_refresh + REFRESH_W'(1);
      if (&r_refresh) begin
        if (r_idx == c_IW'(NUM_DIGITS - 1)) r_idx <= '0;
        else                                r_idx <= r_idx + c_IW'(1);
      end
    end
  end

  // Explicit compare-mux keeps unused index codes (non-power-of-2 counts)
  // from selecting out-of-range nibbles.
  always_comb begin
    w_digit = 4'd0;
    w_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_nz[i] = |r_disp[4*i +: 4];
      if (r_idx == c_IW'(i)) begin
        w_digit = r_disp[4*i +: 4];
        w_dp    = i_dp_in[i];
      end
    end
  end

  // Blank when this digit and every more-significant digit is zero.
  assign w_blank = i_blank_lz && (r_idx != '0) && !(|(w_nz >> r_idx));

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'h0: f_decode = 7'b0000001;  4'h1: f_decode = 7'b1001111;
      4'h2: f_decode = 7'b0010010;  4'h3: f_decode = 7'b0000110;
      4'h4: f_decode = 7'b1001100;  4'h5: f_decode = 7'b0100100;
      4'h6: f_decode = 7'b0100000;  4'h7: f_decode = 7'b0001111;
      4'h8: f_decode = 7'b0000000;  4'h9: f_decode = 7'b0000100;
      4'hA: f_decode = 7'b0001000;  4'hB: f_decode = 7'b1100000;
      4'hC: f_decode = 7'b0110001;  4'hD: f_decode = 7'b1000010;
      4'hE: f_decode = 7'b0110000;  default: f_decode = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    if (r_overflow)   w_seg = 7'b1111110;
    else if (w_blank) w_seg = 7'b1111111;
    else              w_seg = f_decode(w_digit);
  end

  assign w_an_sel = ~(NUM_DIGITS'(1) << r_idx);

`ifdef SSEG_DIM_EN
  // PWM the anode within each dwell using the top refresh bits.
  assign w_an = (r_refresh[REFRESH_W-1 -: 4] <= i_brightness) ? w_an_sel : '1;
`else
  assign w_an = w_an_sel;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg_n <= 7'b0000001;
      r_dp_n  <= 1'b1;
      r_an_n  <= ~NUM_DIGITS'(1);
    end else begin
      r_seg_n <= w_seg;
      r_dp_n  <= ~w_dp;
      r_an_n  <= w_an;
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_overflow = r_overflow;
  assign o_seg_n    = r_seg_n;
  assign o_dp_n     = r_dp_n;
  assign o_an_n     = r_an_n;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan_bcd
//  Purpose  : Directed self-checking bench for sseg_scan_bcd (4 digits,
//             14-bit input, 16-cycle dwell). Covers dimming when SSEG_DIM_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_bcd;

  localparam int ND = 4;
  localparam int BW = 14;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] value = '0;
  logic          load = 1'b0;
  logic          hex_mode = 1'b0;
  logic          blank_lz = 1'b0;
  logic [ND-1:0] dp_in = '0;
`ifdef SSEG_DIM_EN
  logic [3:0]    brightness = 4'd15;
`endif
  logic          busy;
  logic          overflow;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [ND-1:0] an_n;

  int n_assert = 0;
  int n_fail   = 0;

  sseg_scan_bcd #(.NUM_DIGITS(ND), .BIN_W(BW), .REFRESH_W(RW)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_value     (value),
    .i_load      (load),
    .i_hex_mode  (hex_mode),
    .i_blank_lz  (blank_lz),
    .i_dp_in     (dp_in),
`ifdef SSEG_DIM_EN
    .i_brightness(brightness),
`endif
    .o_busy      (busy),
    .o_overflow  (overflow),
    .o_seg_n     (seg_n),
    .o_dp_n      (dp_n),
    .o_an_n      (an_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [BW-1:0] v, input logic hx);
    @(negedge clk);
    value    = v;
    hex_mode = hx;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Wait for conversion to finish, plus one cycle so registered segments
  // reflect the freshly committed display register.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(busy === 1'b0), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_digit(input int idx, input logic [6:0] seg, input logic dp,
                             input string tag);
    logic [ND-1:0] an_exp;
    int n;
    an_exp = ~(4'b0001 << idx);
    n = 0;
    while (an_n !== an_exp && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_found"}, 32'(an_n === an_exp), 32'd1);
    chk({tag, "_seg"}, 32'(seg_n), 32'(seg));
    chk({tag, "_dp"}, 32'(dp_n), 32'(dp));
  endtask

  initial begin
    int n;

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_seg", 32'(seg_n), 32'b0000001);
    chk("rst_dp", 32'(dp_n), 32'd1);
    chk("rst_an", 32'(an_n), 32'b1110);
    reset = 1'b0;

    // ---- idle scan: all digits "0", no blanking
    for (int i = 0; i < ND; i++) check_digit(i, 7'b0000001, 1'b1, "idle");

    // ---- dwell length
    n = 0;
    while (an_n !== 4'b1101 && n < 80) begin @(negedge clk); n++; end
    n = 0;
    while (an_n === 4'b1101 && n < 100) begin @(negedge clk); n++; end
    chk("dwell_cycles", 32'(n), 32'd16);
    chk("dwell_next_an", 32'(an_n), 32'b1011);

    // ---- decimal 1234
    do_load(14'd1234, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    chk("busy_cycles", 32'(n), 32'd15);
    @(negedge clk);
    chk("d1234_ovf", 32'(overflow), 32'd0);
    check_digit(0, 7'b1001100, 1'b1, "d1234_0");
    check_digit(1, 7'b0000110, 1'b1, "d1234_1");
    check_digit(2, 7'b0010010, 1'b1, "d1234_2");
    check_digit(3, 7'b1001111, 1'b1, "d1234_3");

    // ---- decimal 7 with blanking and dp on digit 2
    blank_lz = 1'b1;
    dp_in    = 4'b0100;
    do_load(14'd7, 1'b0);
    wait_idle("d7");
    check_digit(0, 7'b0001111, 1'b1, "d7_0");
    check_digit(1, 7'b1111111, 1'b1, "d7_1");
    check_digit(2, 7'b1111111, 1'b0, "d7_2");
    check_digit(3, 7'b1111111, 1'b1, "d7_3");

    // ---- decimal overflow, then cleared by a fitting value
    do_load(14'd12000, 1'b0);
    wait_idle("d12000");
    chk("d12000_ovf", 32'(overflow), 32'd1);
    check_digit(0, 7'b1111110, 1'b1, "d12000_0");
    check_digit(2, 7'b1111110, 1'b0, "d12000_2");
    check_digit(3, 7'b1111110, 1'b1, "d12000_3");
    do_load(14'd5, 1'b0);
    wait_idle("d5");
    chk("d5_ovf", 32'(overflow), 32'd0);
    check_digit(0, 7'b0100100, 1'b1, "d5_0");
    check_digit(1, 7'b1111111, 1'b1, "d5_1");

    // ---- hex pass-through
    blank_lz = 1'b0;
    dp_in    = 4'b0000;
    do_load(14'h3A5C, 1'b1);
    chk("hex_busy", 32'(busy), 32'd0);
    chk("hex_ovf", 32'(overflow), 32'd0);
    wait_idle("hex");
    check_digit(0, 7'b0110001, 1'b1, "hex_0");
    check_digit(1, 7'b0100100, 1'b1, "hex_1");
    check_digit(2, 7'b0001000, 1'b1, "hex_2");
    check_digit(3, 7'b0000110, 1'b1, "hex_3");

    // ---- load while busy is ignored
    do_load(14'd1234, 1'b0);
    repeat (3) @(negedge clk);
    do_load(14'h0FFF, 1'b1);
    chk("ign_busy", 32'(busy), 32'd1);
    wait_idle("ign");
    check_digit(0, 7'b1001100, 1'b1, "ign_0");
    check_digit(3, 7'b1001111, 1'b1, "ign_3");

    // ---- reset in the middle of SHIFT
    do_load(14'd99, 1'b0);
    repeat (5) @(negedge clk);
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_seg", 32'(seg_n), 32'b0000001);
    chk("midrst_an", 32'(an_n), 32'b1110);
    chk("midrst_dp", 32'(dp_n), 32'd1);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_digit(3, 7'b0000001, 1'b1, "midrst_3");

`ifdef SSEG_DIM_EN
    // ---- dimming: 4 lit cycles out of every 16-cycle dwell
    brightness = 4'd3;
    repeat (2) @(negedge clk);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (an_n !== 4'b1111) n++;
      @(negedge clk);
    end
    chk("dim_on_cycles", 32'(n), 32'd16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
